uart_frame_assembler: RTL and testbench

- Sits directly downstream of the UART receiver. Consumes its one-cycle byte strobes and assembles framed 16-bit samples.
- Each frame is buffered internally and checked against an XOR checksum.
- Only frames that pass the check are released to the DFT input as a valid/ready sample stream, with a last-sample marker.
- Malformed, stalled or overrun frames are discarded and reported on an error code.

---
 rtl/uart_frame_assembler.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_frame_assembler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler
// Turns the UART receiver's byte strobes into checksum-verified frames of
// 16-bit samples. A frame is buffered whole, checked, then streamed out on a
// valid/ready interface. Bad, stalled or overrun frames are reported on
// o_Err / o_Err_Code.
module uart_frame_assembler #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         SAMPLE_COUNT = 16,
  parameter int         TIMEOUT_CLKS = 2048
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Sample_Valid,
  input  logic        i_Sample_Ready,
  output logic [15:0] o_Sample,
  output logic        o_Sample_Last,
  output logic        o_Frame_Done,
  output logic        o_Err,
  output logic [1:0]  o_Err_Code
);

  localparam int IDX_W = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CLKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_COUNT - 1);
  // The error flag is registered, so the decision is taken one clock before
  // the pulse; this places the pulse TIMEOUT_CLKS-1 clocks after the last
  // strobe.
  localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT_CLKS - 3);

  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LO,
    S_HI,
    S_CHECK,
    S_OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [7:0]         acc_q, acc_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0]         low_q, low_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [15:0]        sample_q;

  logic               wr_en;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_addr;

  logic [15:0]        sample_mem [SAMPLE_COUNT];

  logic               timed;
  logic               tmo_hit;
  logic               xfer;
  logic               last_xfer;

  assign timed     = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CHECK);
  assign tmo_hit   = timed && !i_Rx_DV && (tmo_q == TMO_FIRE);
  assign xfer      = valid_q && i_Sample_Ready;
  assign last_xfer = xfer && (index_q == LAST_IDX);

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; a strobe always takes priority over a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_d = S_LO;
      end
      S_LO: begin
        if (i_Rx_DV)      state_d = S_HI;
        else if (tmo_hit) state_d = S_SYNC;
      end
      S_HI: begin
        if (i_Rx_DV)      state_d = (index_q == LAST_IDX) ? S_CHECK : S_LO;
        else if (tmo_hit) state_d = S_SYNC;
      end
      S_CHECK: begin
        if (i_Rx_DV)      state_d = (i_Rx_Byte == acc_q) ? S_OUTPUT : S_SYNC;
        else if (tmo_hit) state_d = S_SYNC;
      end
      S_OUTPUT: begin
        if (last_xfer) state_d = S_SYNC;
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Datapath and output next values, buffer write/read controls.
  always_comb begin
    index_d = index_q;
    acc_d   = acc_q;
    tmo_d   = tmo_q;
    low_d   = low_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = index_q;

    case (state_q)
      S_SYNC: begin
        valid_d = 1'b0;
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          index_d = '0;
          acc_d   = '0;
          tmo_d   = '0;
        end
      end
      S_LO: begin
        if (i_Rx_DV) begin
          low_d = i_Rx_Byte;
          acc_d = acc_q ^ i_Rx_Byte;
        end
      end
      S_HI: begin
        if (i_Rx_DV) begin
          wr_en = 1'b1;
          acc_d = acc_q ^ i_Rx_Byte;
          if (index_q != LAST_IDX) index_d = index_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == acc_q) begin
            index_d = '0;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHECKSUM;
          end
        end
      end
      S_OUTPUT: begin
        // Incoming bytes cannot be stored while draining: drop and flag.
        if (i_Rx_DV) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (!valid_q) begin
          // First cycle of output: fetch sample 0.
          rd_en   = 1'b1;
          valid_d = 1'b1;
        end else if (xfer) begin
          if (index_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            index_d = '0;
          end else begin
            // Fetch the next sample now so it is presented without a bubble.
            index_d = index_q + 1'b1;
            rd_addr = index_q + 1'b1;
            rd_en   = 1'b1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase

    // Inter-byte watchdog for the receiving states.
    if (timed) begin
      if (i_Rx_DV) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_FIRE) begin
        err_d  = 1'b1;
        code_d = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      index_q <= '0;
      acc_q   <= '0;
      tmo_q   <= '0;
      low_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      index_q <= index_d;
      acc_q   <= acc_d;
      tmo_q   <= tmo_d;
      low_q   <= low_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Frame buffer write port: one sample per high byte.
  always_ff @(posedge i_Clock) begin
    if (wr_en) sample_mem[index_q] <= {i_Rx_Byte, low_q};
  end

  // Frame buffer registered read port, doubling as the output data register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sample_q <= '0;
    end else if (rd_en) begin
      sample_q <= sample_mem[rd_addr];
    end
  end

  assign o_Sample_Valid = valid_q;
  assign o_Sample       = sample_q;
  assign o_Sample_Last  = valid_q && (index_q == LAST_IDX);
  assign o_Frame_Done   = done_q;
  assign o_Err          = err_q;
  assign o_Err_Code     = code_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler with a 4-sample frame and a 64-clock
// inter-byte watchdog.
module tb_uart_frame_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [7:0]  rx;
  logic        rdy;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        f_done;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  uart_frame_assembler #(
    .SYNC_BYTE   (8'hA5),
    .SAMPLE_COUNT(4),
    .TIMEOUT_CLKS(64)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Rx_DV       (dv),
    .i_Rx_Byte     (rx),
    .o_Sample_Valid(s_valid),
    .i_Sample_Ready(rdy),
    .o_Sample      (s_data),
    .o_Sample_Last (s_last),
    .o_Frame_Done  (f_done),
    .o_Err         (err),
    .o_Err_Code    (err_code)
  );

  typedef struct {
    logic        rst;
    logic        dv;
    logic [7:0]  b;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_sample;
    logic        e_last;
    logic        e_done;
    logic        e_err;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vt [64];
  int   nv = 0;

  int checks = 0;
  int errors = 0;

  // Observed transfers {last, sample}, error codes and done pulses.
  logic [16:0] act_q [$];
  logic [1:0]  err_q [$];
  int          done_cnt = 0;
  bit          rand_ready = 1'b0;

  logic        pv, pr, pl, prst;
  logic [15:0] ps;

  logic [15:0] gf [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Record what happens in the current cycle, advance one clock, then
  // verify that a stalled sample was held.
  task automatic tick();
    if (s_valid === 1'b1 && rdy === 1'b1) act_q.push_back({s_last, s_data});
    if (err === 1'b1) err_q.push_back(err_code);
    if (f_done === 1'b1) done_cnt++;
    pv = s_valid; pr = rdy; ps = s_data; pl = s_last; prst = rst;
    @(posedge clk);
    #1;
    if (pv === 1'b1 && pr === 1'b0 && prst === 1'b0) begin
      chk("hold_valid",  32'(s_valid), 32'd1);
      chk("hold_sample", 32'(s_data),  32'(ps));
      chk("hold_last",   32'(s_last),  32'(pl));
    end
    if (rand_ready) rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    dv = 1'b1;
    rx = b;
    tick();
    dv = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [15:0] s [4], input logic [7:0] cs_flip, input int max_gap);
    logic [7:0] x;
    x = 8'h00;
    send_byte(8'hA5, $urandom_range(0, max_gap));
    for (int i = 0; i < 4; i++) begin
      x = x ^ s[i][7:0] ^ s[i][15:8];
      send_byte(s[i][7:0],  $urandom_range(0, max_gap));
      send_byte(s[i][15:8], $urandom_range(0, max_gap));
    end
    send_byte(x ^ cs_flip, 0);
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_seen", 32'(done_cnt != start), 32'd1);
  endtask

  task automatic check_frame(input logic [15:0] e [4]);
    chk("xfer_count", 32'(act_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < act_q.size(); i++) begin
      chk($sformatf("xfer%0d_sample", i), 32'(act_q[i][15:0]), 32'(e[i]));
      chk($sformatf("xfer%0d_last", i),   32'(act_q[i][16]),   32'(i == 3));
    end
    act_q.delete();
  endtask

  task automatic clear_obs();
    act_q.delete();
    err_q.delete();
  endtask

  task automatic add_vec(input logic r, input logic d, input logic [7:0] b, input logic rd,
                         input logic ev, input logic [15:0] es, input logic el,
                         input logic ed, input logic ee, input logic [1:0] ec);
    vt[nv].rst = r;   vt[nv].dv = d;        vt[nv].b = b;       vt[nv].rdy = rd;
    vt[nv].e_valid = ev; vt[nv].e_sample = es; vt[nv].e_last = el;
    vt[nv].e_done = ed;  vt[nv].e_err = ee;    vt[nv].e_code = ec;
    nv++;
  endtask

  initial begin
    logic [7:0]  fr [10];
    logic [15:0] rs [4];
    logic [7:0]  nb;
    logic [1:0]  tcode;
    int          first_k;
    bit          bad;
    int          pat [7];

    fr = '{8'hA5, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hBE};
    gf = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
    pat = '{1, 0, 0, 1, 0, 1, 1};

    // Each row: inputs for one cycle, outputs expected after that edge.
    add_vec(1, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 2'b00);
    add_vec(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 2'b00);
    for (int i = 0; i < 10; i++) add_vec(0, 1, fr[i], 1, 0, 16'h0000, 0, 0, 0, 2'b00);
    add_vec(0, 0, 8'h00, 1, 1, 16'h1234, 0, 0, 0, 2'b00);
    add_vec(0, 0, 8'h00, 1, 1, 16'hABCD, 0, 0, 0, 2'b00);
    add_vec(0, 0, 8'h00, 1, 1, 16'h0001, 0, 0, 0, 2'b00);
    add_vec(0, 0, 8'h00, 1, 1, 16'hFF00, 1, 0, 0, 2'b00);
    add_vec(0, 0, 8'h00, 1, 0, 16'h0000, 0, 1, 0, 2'b00);
    add_vec(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 2'b00);
    for (int i = 0; i < 9; i++) add_vec(0, 1, fr[i], 1, 0, 16'h0000, 0, 0, 0, 2'b00);
    add_vec(0, 1, 8'hBF, 1, 0, 16'h0000, 0, 0, 1, 2'b01);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 2'b00);

    rst = 1'b1; dv = 1'b0; rx = 8'h00; rdy = 1'b1;

    // Good frame with ready high, then the same frame with a bad checksum.
    for (int i = 0; i < nv; i++) begin
      rst = vt[i].rst; dv = vt[i].dv; rx = vt[i].b; rdy = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_sample", i), 32'(s_data), 32'(vt[i].e_sample));
        chk($sformatf("vec%0d_last", i),   32'(s_last), 32'(vt[i].e_last));
      end
      chk($sformatf("vec%0d_done", i), 32'(f_done), 32'(vt[i].e_done));
      chk($sformatf("vec%0d_err", i),  32'(err),    32'(vt[i].e_err));
      if (vt[i].e_err) chk($sformatf("vec%0d_code", i), 32'(err_code), 32'(vt[i].e_code));
    end
    rst = 1'b0; dv = 1'b0;
    clear_obs();

    // Backpressure: good frame accepted after the bad one, ready toggling.
    rdy = 1'b1;
    send_byte(8'hA5, 0);
    for (int i = 1; i < 9; i++) send_byte(fr[i], 0);
    dv = 1'b1; rx = 8'hBE;
    tick();
    dv = 1'b0;
    for (int p = 0; p < 7; p++) begin
      rdy = 1'(pat[p]);
      tick();
    end
    rdy = 1'b1;
    wait_done(50);
    check_frame(gf);
    chk("bp_no_err", 32'(err_q.size()), 32'd0);
    clear_obs();

    // Timeout after A5 34 12.
    send_byte(8'hA5, 0);
    send_byte(8'h34, 0);
    dv = 1'b1; rx = 8'h12;
    tick();
    dv = 1'b0;
    first_k = -1;
    tcode = 2'b00;
    for (int k = 1; k <= 70; k++) begin
      if (err === 1'b1 && first_k < 0) begin
        first_k = k;
        tcode = err_code;
      end
      tick();
    end
    chk("timeout_cycle", 32'(first_k), 32'd63);
    chk("timeout_code",  32'(tcode),   32'd2);
    chk("timeout_single", 32'(err_q.size()), 32'd1);
    clear_obs();
    send_byte(8'h34, 10);
    chk("stray_no_err",   32'(err_q.size()), 32'd0);
    chk("stray_no_valid", 32'(act_q.size()), 32'd0);
    send_frame(gf, 8'h00, 0);
    wait_done(50);
    check_frame(gf);
    clear_obs();

    // Noise before the frame, overrun while draining under backpressure.
    rdy = 1'b0;
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_frame(gf, 8'h00, 0);
    repeat (4) tick();
    send_byte(8'h55, 2);
    chk("overrun_count", 32'(err_q.size()), 32'd1);
    if (err_q.size() > 0) chk("overrun_code", 32'(err_q[0]), 32'd3);
    chk("overrun_held_valid",  32'(s_valid), 32'd1);
    chk("overrun_held_sample", 32'(s_data),  32'h1234);
    rdy = 1'b1;
    wait_done(50);
    check_frame(gf);
    clear_obs();

    // Reset after 5 payload bytes.
    send_byte(8'hA5, 0);
    for (int i = 1; i < 6; i++) send_byte(fr[i], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid",  32'(s_valid),  32'd0);
    chk("rst_sample", 32'(s_data),   32'd0);
    chk("rst_last",   32'(s_last),   32'd0);
    chk("rst_done",   32'(f_done),   32'd0);
    chk("rst_err",    32'(err),      32'd0);
    chk("rst_code",   32'(err_code), 32'd0);
    repeat (3) tick();
    chk("rst_no_err", 32'(err_q.size()), 32'd0);
    send_frame(gf, 8'h00, 0);
    wait_done(50);
    check_frame(gf);
    clear_obs();

    // Random frames against the frame-level model.
    rand_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h00;
        send_byte(nb, $urandom_range(0, 3));
      end
      for (int i = 0; i < 4; i++) rs[i] = 16'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      clear_obs();
      send_frame(rs, bad ? 8'($urandom_range(1, 255)) : 8'h00, 4);
      if (!bad) begin
        wait_done(200);
        check_frame(rs);
        chk($sformatf("rand%0d_no_err", f), 32'(err_q.size()), 32'd0);
      end else begin
        repeat (3) tick();
        chk($sformatf("rand%0d_err_count", f), 32'(err_q.size()), 32'd1);
        if (err_q.size() > 0) chk($sformatf("rand%0d_err_code", f), 32'(err_q[0]), 32'd1);
        chk($sformatf("rand%0d_no_xfer", f), 32'(act_q.size()), 32'd0);
      end
      clear_obs();
    end
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
